// File: rtl/hello_uart_rx.sv
// UART 8N1 receiver with a "HELLO" sequence detector on the accepted byte stream.
// Latency: rx_valid 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start edge; hello_match same cycle as rx_valid.
// Backpressure: none; pulses are single-cycle and must be consumed when issued.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous active-low reset
//   serial_rx    asynchronous UART line (idle high, LSB first)
//   rx_byte      last correctly framed byte, held until the next good frame
//   rx_valid     one-cycle pulse, rx_byte is new in that cycle
//   frame_err    one-cycle pulse, stop bit sampled low
//   hello_match  one-cycle pulse when the byte stream completes "HELLO"
//   match_count  number of hello_match pulses since reset (wraps)
module hello_uart_rx #(
    parameter int CLKS_PER_BIT = 1231,
    parameter int DATA_WIDTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       hello_match,
    output logic [7:0] match_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
    typedef enum logic [2:0] {M_IDLE, M_H, M_HE, M_HEL, M_HELL} m_state_t;

    rx_state_t        state, state_nxt;
    m_state_t         m_state, m_nxt;
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             cnt_clr, take_bit, stop_smp;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= serial_rx;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        take_bit  = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!sync2) state_nxt = START;
            end
            START: begin
                // Mid-start-bit check rejects short glitches.
                if (cnt == HALF_M1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    take_bit = 1'b1;
                    if (bit_idx == LAST_BIT) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_clr   = 1'b1;
                    stop_smp  = 1'b1;
                    state_nxt = sync2 ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_clr = 1'b1;
                if (sync2) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_clr ? '0 : cnt + 1'b1;
            rx_valid  <= stop_smp & sync2;
            frame_err <= stop_smp & ~sync2;
            if (state == IDLE) bit_idx <= '0;
            else if (take_bit) bit_idx <= bit_idx + 1'b1;
            if (take_bit) shreg[bit_idx] <= sync2;
            // A bad stop bit leaves the previous good byte visible.
            if (stop_smp && sync2) rx_byte <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_state     <= M_IDLE;
            match_count <= '0;
        end else begin
            m_state     <= m_nxt;
            match_count <= match_count + {7'd0, hello_match};
        end
    end

    always_comb begin
        logic [7:0] expect_chr;
        m_nxt       = m_state;
        hello_match = 1'b0;
        case (m_state)
            M_IDLE:  expect_chr = 8'h48;
            M_H:     expect_chr = 8'h45;
            M_HE:    expect_chr = 8'h4C;
            M_HEL:   expect_chr = 8'h4C;
            M_HELL:  expect_chr = 8'h4F;
            default: expect_chr = 8'h48;
        endcase
        if (frame_err) begin
            m_nxt = M_IDLE;
        end else if (rx_valid) begin
            if (rx_byte == expect_chr) begin
                case (m_state)
                    M_IDLE:  m_nxt = M_H;
                    M_H:     m_nxt = M_HE;
                    M_HE:    m_nxt = M_HEL;
                    M_HEL:   m_nxt = M_HELL;
                    default: begin
                        m_nxt       = M_IDLE;
                        hello_match = 1'b1;
                    end
                endcase
            end else begin
                // An unexpected 'H' can still begin a fresh "HELLO".
                m_nxt = (rx_byte == 8'h48) ? M_H : M_IDLE;
            end
        end
    end

endmodule
